// File: rtl/wide_bram_port.sv
// Wide-word BRAM port: a WIDTH-bit word is stored as PIECES consecutive BRAM entries,
// with valid/ready handshakes, pipelined piece access and a one-entry last-accessed cache.
module wide_bram_port #(
   parameter int  ADDRS          = 1024,
   parameter int  BRAM_WIDTH     = 64,
   parameter int  PIECES         = 32,
   parameter int  READ_LATENCY   = 2,
   localparam int ADDR_SIZE      = $clog2(ADDRS),
   localparam int WIDTH          = PIECES * BRAM_WIDTH,
   localparam int BRAM_ADDR_SIZE = $clog2(ADDRS * PIECES)
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_SIZE-1:0]      req_addr,
   input  logic [WIDTH-1:0]          req_data,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [WIDTH-1:0]          resp_data,
   output logic [BRAM_ADDR_SIZE-1:0] bram_addr,
   output logic [BRAM_WIDTH-1:0]     bram_din,
   output logic                      bram_we,
   output logic                      bram_regce,
   input  logic [BRAM_WIDTH-1:0]     bram_dout
);

   localparam int CNT_W = (PIECES > 1) ? $clog2(PIECES) : 1;
   localparam logic [CNT_W-1:0] LAST_PIECE = CNT_W'(PIECES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
   localparam logic [BRAM_ADDR_SIZE-1:0] BADDR_ONE = BRAM_ADDR_SIZE'(1'b1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                    state_r, state_nxt;
   logic [ADDR_SIZE-1:0]      addr_r, addr_nxt;
   logic [WIDTH-1:0]          wdata_r, wdata_nxt;
   logic [CNT_W-1:0]          piece_r, piece_nxt;
   logic                      issue_active_r, issue_active_nxt;
   logic [READ_LATENCY:0]     tag_r, tag_nxt;
   logic [CNT_W-1:0]          cap_r, cap_nxt;
   logic [WIDTH-1:0]          asm_r, asm_nxt;
   logic                      cache_valid_r, cache_valid_nxt;
   logic [ADDR_SIZE-1:0]      cache_addr_r, cache_addr_nxt;
   logic [WIDTH-1:0]          cache_data_r, cache_data_nxt;
   logic                      resp_valid_r, resp_valid_nxt;
   logic [WIDTH-1:0]          resp_data_r, resp_data_nxt;
   logic [BRAM_ADDR_SIZE-1:0] bram_addr_r, bram_addr_nxt;
   logic [BRAM_WIDTH-1:0]     bram_din_r, bram_din_nxt;
   logic                      bram_we_r, bram_we_nxt;
   logic                      bram_regce_r, bram_regce_nxt;

   logic                      issue_s;
   logic                      hit_s;
   logic                      capture_s;
   logic [BRAM_ADDR_SIZE-1:0] base_s;
   logic [WIDTH-1:0]          asm_s;

   assign base_s    = BRAM_ADDR_SIZE'(req_addr) * BRAM_ADDR_SIZE'(PIECES);
   assign hit_s     = cache_valid_r && (cache_addr_r == req_addr);
   assign capture_s = tag_r[READ_LATENCY];
   // Pieces arrive lowest first, so shifting right leaves piece 0 at the bottom.
   assign asm_s     = (asm_r >> BRAM_WIDTH) | (WIDTH'(bram_dout) << (WIDTH - BRAM_WIDTH));
   assign tag_nxt   = {tag_r[READ_LATENCY-1:0], issue_s};

   assign req_ready  = (state_r == IDLE);
   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_data_r;
   assign bram_addr  = bram_addr_r;
   assign bram_din   = bram_din_r;
   assign bram_we    = bram_we_r;
   assign bram_regce = bram_regce_r;

   // Next-state and next-output logic for the request/response FSM.
   always_comb begin
      state_nxt        = state_r;
      addr_nxt         = addr_r;
      wdata_nxt        = wdata_r;
      piece_nxt        = piece_r;
      issue_active_nxt = issue_active_r;
      cap_nxt          = cap_r;
      asm_nxt          = asm_r;
      cache_valid_nxt  = cache_valid_r;
      cache_addr_nxt   = cache_addr_r;
      cache_data_nxt   = cache_data_r;
      resp_valid_nxt   = resp_valid_r;
      resp_data_nxt    = resp_data_r;
      bram_addr_nxt    = bram_addr_r;
      bram_din_nxt     = bram_din_r;
      bram_we_nxt      = 1'b0;
      issue_s          = 1'b0;

      case (state_r)
         IDLE: begin
            if (req_valid) begin
               addr_nxt = req_addr;
               if (req_write) begin
                  state_nxt       = WRITE;
                  cache_valid_nxt = 1'b1;
                  cache_addr_nxt  = req_addr;
                  cache_data_nxt  = req_data;
                  bram_we_nxt     = 1'b1;
                  bram_addr_nxt   = base_s;
                  bram_din_nxt    = req_data[BRAM_WIDTH-1:0];
                  wdata_nxt       = req_data >> BRAM_WIDTH;
                  piece_nxt       = '0;
               end else if (hit_s) begin
                  state_nxt      = RESP;
                  resp_valid_nxt = 1'b1;
                  resp_data_nxt  = cache_data_r;
               end else begin
                  state_nxt        = READ;
                  bram_addr_nxt    = base_s;
                  issue_s          = 1'b1;
                  issue_active_nxt = 1'b1;
                  piece_nxt        = '0;
                  cap_nxt          = '0;
               end
            end else begin
               state_nxt = IDLE;
            end
         end

         WRITE: begin
            if (piece_r == LAST_PIECE) begin
               state_nxt = IDLE;
            end else begin
               piece_nxt     = piece_r + CNT_ONE;
               bram_we_nxt   = 1'b1;
               bram_addr_nxt = bram_addr_r + BADDR_ONE;
               bram_din_nxt  = wdata_r[BRAM_WIDTH-1:0];
               wdata_nxt     = wdata_r >> BRAM_WIDTH;
            end
         end

         READ: begin
            if (issue_active_r && (piece_r != LAST_PIECE)) begin
               piece_nxt     = piece_r + CNT_ONE;
               bram_addr_nxt = bram_addr_r + BADDR_ONE;
               issue_s       = 1'b1;
            end else begin
               issue_active_nxt = 1'b0;
            end
            // A set tag at the end of the shift register means bram_dout holds a piece now.
            if (capture_s) begin
               asm_nxt = asm_s;
               cap_nxt = cap_r + CNT_ONE;
               if (cap_r == LAST_PIECE) begin
                  state_nxt       = RESP;
                  resp_valid_nxt  = 1'b1;
                  resp_data_nxt   = asm_s;
                  cache_valid_nxt = 1'b1;
                  cache_addr_nxt  = addr_r;
                  cache_data_nxt  = asm_s;
               end else begin
                  state_nxt = READ;
               end
            end else begin
               asm_nxt = asm_r;
            end
         end

         RESP: begin
            if (resp_ready) begin
               state_nxt      = IDLE;
               resp_valid_nxt = 1'b0;
            end else begin
               state_nxt = RESP;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      bram_regce_nxt = (state_nxt != WRITE);
   end

   // State, datapath and registered BRAM/response outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r        <= IDLE;
         addr_r         <= '0;
         wdata_r        <= '0;
         piece_r        <= '0;
         issue_active_r <= 1'b0;
         tag_r          <= '0;
         cap_r          <= '0;
         asm_r          <= '0;
         cache_valid_r  <= 1'b0;
         cache_addr_r   <= '0;
         cache_data_r   <= '0;
         resp_valid_r   <= 1'b0;
         resp_data_r    <= '0;
         bram_addr_r    <= '0;
         bram_din_r     <= '0;
         bram_we_r      <= 1'b0;
         bram_regce_r   <= 1'b1;
      end else begin
         state_r        <= state_nxt;
         addr_r         <= addr_nxt;
         wdata_r        <= wdata_nxt;
         piece_r        <= piece_nxt;
         issue_active_r <= issue_active_nxt;
         tag_r          <= tag_nxt;
         cap_r          <= cap_nxt;
         asm_r          <= asm_nxt;
         cache_valid_r  <= cache_valid_nxt;
         cache_addr_r   <= cache_addr_nxt;
         cache_data_r   <= cache_data_nxt;
         resp_valid_r   <= resp_valid_nxt;
         resp_data_r    <= resp_data_nxt;
         bram_addr_r    <= bram_addr_nxt;
         bram_din_r     <= bram_din_nxt;
         bram_we_r      <= bram_we_nxt;
         bram_regce_r   <= bram_regce_nxt;
      end
   end

endmodule

// File: tb/tb_wide_bram_port.sv
// Directed bench for wide_bram_port: PIECES=4, BRAM_WIDTH=8, one DUT at READ_LATENCY=2
// and one at READ_LATENCY=1, each backed by a BRAM model preloaded with mem[i]=i.
module tb_wide_bram_port;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // DUT 0: ADDRS=16, READ_LATENCY=2
   logic        req_valid, req_ready, req_write;
   logic [3:0]  req_addr;
   logic [31:0] req_data;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [5:0]  bram_addr;
   logic [7:0]  bram_din, bram_dout;
   logic        bram_we, bram_regce;

   // DUT 1: ADDRS=1024, READ_LATENCY=1
   logic        req_valid1, req_ready1, req_write1;
   logic [9:0]  req_addr1;
   logic [31:0] req_data1;
   logic        resp_valid1, resp_ready1;
   logic [31:0] resp_data1;
   logic [11:0] bram_addr1;
   logic [7:0]  bram_din1, bram_dout1;
   logic        bram_we1, bram_regce1;

   int checks   = 0;
   int failures = 0;

   wide_bram_port #(.ADDRS(16), .BRAM_WIDTH(8), .PIECES(4), .READ_LATENCY(2)) dut0 (
      .clk_in(clk), .rst_in(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
      .bram_regce(bram_regce), .bram_dout(bram_dout)
   );

   wide_bram_port #(.ADDRS(1024), .BRAM_WIDTH(8), .PIECES(4), .READ_LATENCY(1)) dut1 (
      .clk_in(clk), .rst_in(rst),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
      .req_addr(req_addr1), .req_data(req_data1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_data(resp_data1),
      .bram_addr(bram_addr1), .bram_din(bram_din1), .bram_we(bram_we1),
      .bram_regce(bram_regce1), .bram_dout(bram_dout1)
   );

   // Two-stage BRAM model: memory latch then output register gated by regce.
   logic [7:0] mem0 [0:63];
   logic [7:0] pipe0;
   bit         init0 = 1'b0;
   always @(posedge clk) begin
      if (!init0) begin
         for (int i = 0; i < 64; i++) mem0[i] <= 8'(i);
         init0 <= 1'b1;
      end else if (bram_we) begin
         mem0[bram_addr] <= bram_din;
      end
      pipe0 <= mem0[bram_addr];
      if (bram_regce) bram_dout <= pipe0;
   end

   // Single-stage BRAM model.
   logic [7:0] mem1 [0:4095];
   bit         init1 = 1'b0;
   always @(posedge clk) begin
      if (!init1) begin
         for (int j = 0; j < 4096; j++) mem1[j] <= 8'(j);
         init1 <= 1'b1;
      end else if (bram_we1) begin
         mem1[bram_addr1] <= bram_din1;
      end
      if (bram_regce1) bram_dout1 <= mem1[bram_addr1];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue a read on DUT 0, check addresses, latency and data, optionally hold the response.
   task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input int exp_lat,
                          input int hold, input int base, input string tag);
      int lat;
      lat        = -1;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = a;
      resp_ready = 1'b0;
      @(posedge clk);
      for (int c = 0; c < 20 && lat < 0; c++) begin
         @(negedge clk);
         if (c == 0) begin
            req_valid = 1'b0;
            chk({tag, "_busy"}, 64'(req_ready), 64'(0));
         end
         if (base >= 0 && c < 4) chk({tag, "_baddr"}, 64'(bram_addr), 64'(base + c));
         if (resp_valid) lat = c;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_data"}, 64'(resp_data), 64'(exp));
      for (int h = 0; h < hold; h++) begin
         req_valid = (h == 3);
         req_write = (h == 3);
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(resp_valid), 64'(1));
         chk({tag, "_hold_data"}, 64'(resp_data), 64'(exp));
         chk({tag, "_hold_rdy"}, 64'(req_ready), 64'(0));
         chk({tag, "_hold_we"}, 64'(bram_we), 64'(0));
      end
      req_valid  = 1'b0;
      req_write  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_done_valid"}, 64'(resp_valid), 64'(0));
      chk({tag, "_done_rdy"}, 64'(req_ready), 64'(1));
      chk({tag, "_done_we"}, 64'(bram_we), 64'(0));
      resp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] wd;
      int          lat1;

      req_valid  = 1'b0; req_write  = 1'b0; req_addr  = '0; req_data  = '0; resp_ready  = 1'b0;
      req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_data1 = '0; resp_ready1 = 1'b0;

      // Reset state, observed before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_resp_data", 64'(resp_data), 64'(0));
      chk("rst_bram_we", 64'(bram_we), 64'(0));
      chk("rst_bram_addr", 64'(bram_addr), 64'(0));
      chk("rst_bram_din", 64'(bram_din), 64'(0));
      chk("rst_bram_regce", 64'(bram_regce), 64'(1));
      chk("rst_req_ready1", 64'(req_ready1), 64'(1));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1: miss on addr 3, 2: hit on addr 3
      do_read(4'd3, 32'h0F0E0D0C, 6, 0, 12, "t1_miss3");
      do_read(4'd3, 32'h0F0E0D0C, 0, 0, -1, "t2_hit3");
      chk("t2_baddr_stays", 64'(bram_addr), 64'(15));

      // 3: write addr 5; request inputs change while busy and must be ignored
      wd        = 32'hA1B2C3D4;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 4'd5;
      req_data  = wd;
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c < 4) begin
            chk("t3_we", 64'(bram_we), 64'(1));
            chk("t3_addr", 64'(bram_addr), 64'(20 + c));
            chk("t3_din", 64'(bram_din), 64'(wd[c*8 +: 8]));
            chk("t3_rdy", 64'(req_ready), 64'(0));
            chk("t3_regce", 64'(bram_regce), 64'(0));
         end else begin
            chk("t3_we_end", 64'(bram_we), 64'(0));
            chk("t3_rdy_end", 64'(req_ready), 64'(1));
            chk("t3_regce_end", 64'(bram_regce), 64'(1));
         end
         if (c == 0) begin
            req_valid = 1'b0;
            req_write = 1'b0;
            req_addr  = 4'd9;
            req_data  = 32'hDEADBEEF;
         end
      end
      do_read(4'd5, wd, 0, 0, -1, "t3_hit5");
      // 4: miss on addr 6 with 10 cycles of backpressure and a pulsed request
      do_read(4'd6, 32'h1B1A1918, 6, 10, 24, "t4_miss6_bp");
      do_read(4'd5, wd, 6, 0, 20, "t3_miss5");

      // 5: reset between edges while piece 2 is on the BRAM address bus
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 4'd3;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_piece2_addr", 64'(bram_addr), 64'(14));
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_req_ready", 64'(req_ready), 64'(1));
      chk("t5_rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("t5_rst_resp_data", 64'(resp_data), 64'(0));
      chk("t5_rst_bram_addr", 64'(bram_addr), 64'(0));
      chk("t5_rst_bram_we", 64'(bram_we), 64'(0));
      chk("t5_rst_bram_din", 64'(bram_din), 64'(0));
      chk("t5_rst_bram_regce", 64'(bram_regce), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      do_read(4'd3, 32'h0F0E0D0C, 6, 0, 12, "t5_after_rst");

      // 6: READ_LATENCY=1 build, last address
      lat1       = -1;
      req_valid1 = 1'b1;
      req_addr1  = 10'd1023;
      @(posedge clk);
      for (int c = 0; c < 20 && lat1 < 0; c++) begin
         @(negedge clk);
         if (c == 0) req_valid1 = 1'b0;
         if (c < 4) chk("t6_baddr", 64'(bram_addr1), 64'(4092 + c));
         if (resp_valid1) lat1 = c;
      end
      chk("t6_lat", 64'(lat1), 64'(5));
      chk("t6_data", 64'(resp_data1), 64'(32'hFFFEFDFC));
      resp_ready1 = 1'b1;
      @(negedge clk);
      chk("t6_done_valid", 64'(resp_valid1), 64'(0));
      chk("t6_done_rdy", 64'(req_ready1), 64'(1));
      resp_ready1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wide_bram_port.md
Name: wide_bram_port

Overview:
Successor to the team's single-address wide-word BRAM wrapper. Stores words of WIDTH = PIECES*BRAM_WIDTH bits as PIECES consecutive BRAM entries, least-significant piece at the lowest address (base = addr*PIECES).
Adds valid/ready request and response handshakes, a configurable BRAM read latency, and fully pipelined piece access (one BRAM address per cycle, no idle cycles).
Adds a one-line last-accessed cache, so a repeated read of the same address costs no BRAM traffic.
Sits between a compute engine (weights/activations) and one BRAM port.

Parameters:
ADDRS, 1024, number of wide words stored
BRAM_WIDTH, 64, width of one BRAM entry (one piece)
PIECES, 32, BRAM entries per wide word; must be >= 1
READ_LATENCY, 2, cycles from BRAM sampling the address to bram_dout valid; legal values are 1 and 2
Derived: ADDR_SIZE=$clog2(ADDRS), WIDTH=PIECES*BRAM_WIDTH, BRAM_ADDR_SIZE=$clog2(ADDRS*PIECES)

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  request accepted on a clock edge where req_valid&req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_SIZE  wide-word address
req_data  input  WIDTH  write data
resp_valid  output  1  read data available
resp_ready  input  1  consumer accepts the response
resp_data  output  WIDTH  read data
bram_addr  output  BRAM_ADDR_SIZE  BRAM address, registered
bram_din  output  BRAM_WIDTH  BRAM write data, registered
bram_we  output  1  BRAM write enable, registered
bram_regce  output  1  BRAM output register enable
bram_dout  input  BRAM_WIDTH  BRAM read data

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock):
  - state=IDLE; cache invalid; resp_valid=0, resp_data=0.
  - bram_we=0, bram_addr=0, bram_din=0, bram_regce=1; all in-flight capture tags cleared.
  - A write interrupted by reset leaves the BRAM partially written. This is allowed.
- req_ready=1 only in IDLE (combinational from state); it is 1 after reset.
- IDLE, accept write (req_write=1):
  - Latch req_data; go to WRITE.
  - Cache becomes {addr, req_data} and is marked valid.
- WRITE: drive exactly PIECES consecutive cycles with bram_we=1, bram_addr=base+k, bram_din=data[k*BRAM_WIDTH +: BRAM_WIDTH] for k=0..PIECES-1.
  - Next cycle: bram_we=0, return to IDLE.
  - req_ready is low for PIECES cycles after acceptance. Writes produce no response.
- IDLE, accept read, hit (cache valid and address equal):
  - resp_data=cache data; resp_valid=1 on the next edge; go to RESP.
  - No change on any bram_* output.
- IDLE, accept read, miss: go to READ.
  - READ issues base+k on bram_addr during the k-th cycle after acceptance (k=0..PIECES-1), one address per cycle.
  - A tag shift register of depth READ_LATENCY+1 marks valid captures.
  - Piece k is captured from bram_dout at edge E(k+1+READ_LATENCY) into slot k of the assembly buffer, where E0 is the acceptance edge.
- Last capture at E(PIECES+READ_LATENCY): resp_data=assembled word, resp_valid=1, cache={addr, word} marked valid, go to RESP.
  - Miss latency is PIECES+READ_LATENCY cycles from acceptance to resp_valid.
- RESP: resp_valid and resp_data are held stable until an edge with resp_ready=1. Then resp_valid=0 and state=IDLE.
  - A new request cannot be accepted on the same edge; req_ready rises the cycle after the response handshake.
- bram_regce=1 in every state except WRITE.
- Address arithmetic: base=req_addr*PIECES, computed at BRAM_ADDR_SIZE width. Address ADDRS-1 ends at ADDRS*PIECES-1 with no wrap.
  - req_addr >= ADDRS gives undefined BRAM contents but must not hang the FSM.
- req_valid while req_ready=0 is ignored. The requester must hold its request.
- Changes to req_* while busy have no effect, because the request is latched at acceptance.

Test Plan:
All scenarios use PIECES=4, BRAM_WIDTH=8, READ_LATENCY=2 and a BRAM model whose memory is preloaded with mem[i]=i, unless stated otherwise.

1. Reset, then read addr 3 -> bram_addr 12,13,14,15 on consecutive cycles; resp_valid 6 cycles after acceptance; resp_data=0x0F0E0D0C.
2. Read addr 3 again -> hit; resp_valid the next cycle; bram_addr stays 15; resp_data=0x0F0E0D0C.
3. Write addr 5, data 0xA1B2C3D4 -> bram_we high for 4 cycles; addr 20..23; din D4,C3,B2,A1; req_ready low for 4 cycles.
   - Then read 5 -> hit returning 0xA1B2C3D4.
   - Then read 6 -> miss returning 0x1B1A1918.
   - Then read 5 -> miss returning 0xA1B2C3D4 from the model.
4. Backpressure: hold resp_ready=0 for 10 cycles -> resp_valid and resp_data stable, req_ready=0, and a pulsed req_valid is not accepted.
5. Assert rst_in between clock edges during read piece 2 -> all outputs reset immediately. A following read of addr 3 is a miss and returns correct data.
6. READ_LATENCY=1 build: read addr ADDRS-1 -> bram_addr 4092..4095 (ADDRS=1024); resp_valid 5 cycles after acceptance; data correct.
